// File: rtl/oclib_pkg.sv
// Shared LED-controller types, mode codes and heartbeat timing constants.
package oclib_pkg;

    localparam int unsigned ModeW         = 3;
    localparam int unsigned HbCntW        = 10;
    localparam int unsigned HbPeriodTicks = 1000;
    localparam int unsigned HbPulse0End   = 100;
    localparam int unsigned HbPulse1Start = 200;
    localparam int unsigned HbPulse1End   = 300;

    typedef enum logic [ModeW-1:0] {
        MODE_OFF       = 3'd0,
        MODE_ON        = 3'd1,
        MODE_BLINK     = 3'd2,
        MODE_PWM       = 3'd3,
        MODE_HEARTBEAT = 3'd4
    } led_mode_e;

    // Double-pulse heartbeat: lit during ticks 0-99 and 200-299 of each period.
    function automatic logic hb_on(input logic [HbCntW-1:0] cnt);
        return (cnt < HbCntW'(HbPulse0End)) ||
               ((cnt >= HbCntW'(HbPulse1Start)) && (cnt < HbCntW'(HbPulse1End)));
    endfunction

endpackage

// File: rtl/oclib_tick_gen.sv
// Timebase prescaler: one-cycle tick every ClockHz/TickHz clocks.
module oclib_tick_gen #(
    parameter int unsigned ClockHz = 100_000_000,
    parameter int unsigned TickHz  = 1000
) (
    input  logic clock,
    input  logic resetN,
    output logic tick
);

    localparam int unsigned Div  = ((ClockHz / TickHz) > 0) ? (ClockHz / TickHz) : 1;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Term = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // Next count; tick is high while the count sits at its terminal value.
    always_comb begin
        cnt_d  = (cnt_q == Term) ? '0 : cnt_q + CntW'(1);
        tick_d = (cnt_d == Term);
    end

    // Prescaler state.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/oc_led_ctrl.sv
// Multi-LED controller: per-LED OFF/ON/BLINK/PWM/HEARTBEAT modes with attention override.
module oc_led_ctrl
    import oclib_pkg::*;
#(
    parameter int unsigned         LedCount       = 3,
    parameter int unsigned         ClockHz        = 100_000_000,
    parameter int unsigned         TickHz         = 1000,
    parameter int unsigned         PwmBits        = 8,
    parameter int unsigned         BlinkHalfTicks = 250,
    parameter logic [LedCount-1:0] ResetPattern   = {LedCount{1'b1}}
) (
    input  logic                                          clock,
    input  logic                                          resetN,
    input  logic                                          cfgValid,
    output logic                                          cfgReady,
    input  logic [((LedCount > 1) ? $clog2(LedCount) : 1)-1:0] cfgLed,
    input  logic [ModeW-1:0]                              cfgMode,
    input  logic [PwmBits-1:0]                            cfgLevel,
    output logic                                          cfgError,
    input  logic                                          attn,
    output logic [LedCount-1:0]                           ledOut
);

    localparam int unsigned BlinkW = (BlinkHalfTicks > 1) ? $clog2(BlinkHalfTicks) : 1;
    localparam logic [BlinkW-1:0] BlinkTerm = BlinkW'(BlinkHalfTicks - 1);
    localparam logic [HbCntW-1:0] HbTerm    = HbCntW'(HbPeriodTicks - 1);

    logic                tick;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [HbCntW-1:0]   hb_cnt_q, hb_cnt_d;
    logic [PwmBits-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [ModeW-1:0]    mode_q  [LedCount];
    logic [ModeW-1:0]    mode_d  [LedCount];
    logic [PwmBits-1:0]  level_q [LedCount];
    logic [PwmBits-1:0]  level_d [LedCount];
    logic                cfg_error_q, cfg_error_d;
    logic [LedCount-1:0] led_q, led_d;
    logic [LedCount-1:0] mode_on;
    logic                wr_accept;
    logic                wr_in_range;

    oclib_tick_gen #(
        .ClockHz(ClockHz),
        .TickHz (TickHz)
    ) u_tick_gen (
        .clock (clock),
        .resetN(resetN),
        .tick  (tick)
    );

    // Ready tracks reset directly so the first cycle out of reset can accept a write.
    assign cfgReady = resetN;

    // Counters, config write decode and per-LED output function.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        hb_cnt_d      = hb_cnt_q;
        pwm_cnt_d     = pwm_cnt_q + PwmBits'(1);
        mode_d        = mode_q;
        level_d       = level_q;
        mode_on       = '0;

        if (tick) begin
            if (blink_cnt_q == BlinkTerm) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
            hb_cnt_d = (hb_cnt_q == HbTerm) ? '0 : hb_cnt_q + HbCntW'(1);
        end

        wr_accept   = cfgValid && cfgReady;
        wr_in_range = (32'(cfgLed) < LedCount);
        cfg_error_d = wr_accept && !wr_in_range;

        for (int unsigned i = 0; i < LedCount; i++) begin
            if (wr_accept && wr_in_range && (32'(cfgLed) == i)) begin
                mode_d[i]  = cfgMode;
                level_d[i] = cfgLevel;
            end
            case (led_mode_e'(mode_q[i]))
                MODE_ON:        mode_on[i] = 1'b1;
                MODE_BLINK:     mode_on[i] = blink_phase_q;
                MODE_PWM:       mode_on[i] = (pwm_cnt_q < level_q[i]);
                MODE_HEARTBEAT: mode_on[i] = hb_on(hb_cnt_q);
                default:        mode_on[i] = 1'b0;
            endcase
        end

        led_d = mode_on | {LedCount{attn}};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            hb_cnt_q      <= '0;
            pwm_cnt_q     <= '0;
            cfg_error_q   <= 1'b0;
            led_q         <= ResetPattern;
            for (int unsigned i = 0; i < LedCount; i++) begin
                mode_q[i]  <= ResetPattern[i] ? MODE_ON : MODE_OFF;
                level_q[i] <= '1;
            end
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hb_cnt_q      <= hb_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            cfg_error_q   <= cfg_error_d;
            led_q         <= led_d;
            mode_q        <= mode_d;
            level_q       <= level_d;
        end
    end

    assign cfgError = cfg_error_q;
    assign ledOut   = led_q;

endmodule

// File: tb/tb_oc_led_ctrl.sv
// Directed self-checking bench for oc_led_ctrl (10 cycles/tick, 4-bit PWM, 3 LEDs).
module tb_oc_led_ctrl;

    localparam int unsigned LedCount = 3;
    localparam logic [2:0]  RstPat   = 3'b101;

    logic       clock = 1'b0;
    logic       resetN;
    logic       cfgValid;
    logic       cfgReady;
    logic [1:0] cfgLed;
    logic [2:0] cfgMode;
    logic [3:0] cfgLevel;
    logic       cfgError;
    logic       attn;
    logic [2:0] ledOut;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;   // edges since the last reset release

    oc_led_ctrl #(
        .LedCount      (LedCount),
        .ClockHz       (10000),
        .TickHz        (1000),
        .PwmBits       (4),
        .BlinkHalfTicks(5),
        .ResetPattern  (RstPat)
    ) dut (
        .clock   (clock),
        .resetN  (resetN),
        .cfgValid(cfgValid),
        .cfgReady(cfgReady),
        .cfgLed  (cfgLed),
        .cfgMode (cfgMode),
        .cfgLevel(cfgLevel),
        .cfgError(cfgError),
        .attn    (attn),
        .ledOut  (ledOut)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic do_reset();
        resetN   = 1'b0;
        cfgValid = 1'b0;
        cfgLed   = 2'd0;
        cfgMode  = 3'd0;
        cfgLevel = 4'd0;
        attn     = 1'b0;
        repeat (3) step();
        resetN = 1'b1;
        t      = 0;
    endtask

    task automatic start_write(input logic [1:0] led, input logic [2:0] mode, input logic [3:0] lvl);
        cfgValid = 1'b1;
        cfgLed   = led;
        cfgMode  = mode;
        cfgLevel = lvl;
    endtask

    task automatic test_reset();
        resetN   = 1'b0;
        cfgValid = 1'b0;
        cfgLed   = 2'd0;
        cfgMode  = 3'd0;
        cfgLevel = 4'd0;
        attn     = 1'b0;
        repeat (3) step();
        n_checks++;
        if (ledOut !== RstPat) begin
            n_fail++; $display("FAIL reset_led got %b expected %b", ledOut, RstPat);
        end
        n_checks++;
        if (cfgError !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b expected 0", cfgError);
        end
        n_checks++;
        if (cfgReady !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b expected 0", cfgReady);
        end
        resetN = 1'b1;
        t      = 0;
        #1;
        n_checks++;
        if (cfgReady !== 1'b1) begin
            n_fail++; $display("FAIL release_ready got %b expected 1", cfgReady);
        end
        repeat (20) begin
            step();
            n_checks++;
            if (ledOut !== RstPat || cfgError !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold t=%0d led=%b err=%b expected led=%b err=0", t, ledOut, cfgError, RstPat);
            end
        end
    endtask

    task automatic test_blink();
        logic [2:0] exp;
        do_reset();
        start_write(2'd1, 3'd2, 4'd15);
        step();
        cfgValid = 1'b0;
        n_checks++;
        if (ledOut !== RstPat) begin
            n_fail++; $display("FAIL blink_latency got %b expected %b", ledOut, RstPat);
        end
        repeat (209) begin
            step();
            exp = {1'b1, (((t - 1) / 50) % 2) == 0, 1'b1};
            n_checks++;
            if (ledOut !== exp) begin
                n_fail++; $display("FAIL blink t=%0d got %b expected %b", t, ledOut, exp);
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] lvls [3];
        logic       exp0;
        int         highs;
        lvls = '{4'd4, 4'd0, 4'd15};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            start_write(2'd0, 3'd3, lvls[k]);
            step();
            cfgValid = 1'b0;
            step();
            highs = 0;
            for (int c = 0; c < 48; c++) begin
                step();
                exp0 = (((t - 1) % 16) < int'(lvls[k]));
                if (c < 16 && ledOut[0] === 1'b1) highs++;
                n_checks++;
                if (ledOut !== {1'b1, 1'b0, exp0}) begin
                    n_fail++;
                    $display("FAIL pwm lvl=%0d t=%0d got %b expected %b", lvls[k], t, ledOut, {1'b1, 1'b0, exp0});
                end
            end
            n_checks++;
            if (highs != int'(lvls[k])) begin
                n_fail++; $display("FAIL pwm_duty lvl=%0d got %0d/16 expected %0d/16", lvls[k], highs, lvls[k]);
            end
        end
    endtask

    task automatic test_heartbeat();
        logic exp2;
        int   hb;
        do_reset();
        start_write(2'd2, 3'd4, 4'd15);
        step();
        cfgValid = 1'b0;
        while (t < 10050) begin
            step();
            hb   = ((t - 1) / 10) % 1000;
            exp2 = (hb < 100) || (hb >= 200 && hb < 300);
            n_checks++;
            if (ledOut !== {exp2, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL heartbeat t=%0d got %b expected %b", t, ledOut, {exp2, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_error();
        do_reset();
        repeat (4) step();
        start_write(2'd3, 3'd0, 4'd0);
        step();
        cfgValid = 1'b0;
        n_checks++;
        if (cfgError !== 1'b1 || ledOut !== RstPat) begin
            n_fail++; $display("FAIL err_pulse err=%b led=%b expected err=1 led=%b", cfgError, ledOut, RstPat);
        end
        repeat (6) begin
            step();
            n_checks++;
            if (cfgError !== 1'b0 || ledOut !== RstPat) begin
                n_fail++; $display("FAIL err_after t=%0d err=%b led=%b expected err=0 led=%b", t, cfgError, ledOut, RstPat);
            end
        end
        start_write(2'd2, 3'd1, 4'd15);
        step();
        cfgValid = 1'b0;
        n_checks++;
        if (cfgError !== 1'b0) begin
            n_fail++; $display("FAIL err_inrange got %b expected 0", cfgError);
        end
    endtask

    task automatic test_attn();
        do_reset();
        repeat (4) step();
        attn = 1'b1;
        #1;
        n_checks++;
        if (ledOut !== RstPat) begin
            n_fail++; $display("FAIL attn_comb got %b expected %b", ledOut, RstPat);
        end
        repeat (3) begin
            step();
            n_checks++;
            if (ledOut !== 3'b111) begin
                n_fail++; $display("FAIL attn_on t=%0d got %b expected 111", t, ledOut);
            end
        end
        attn = 1'b0;
        repeat (3) begin
            step();
            n_checks++;
            if (ledOut !== RstPat) begin
                n_fail++; $display("FAIL attn_off t=%0d got %b expected %b", t, ledOut, RstPat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] leds  [4];
        logic [2:0] modes [4];
        logic [2:0] exp   [6];
        leds  = '{2'd1, 2'd1, 2'd0, 2'd2};
        modes = '{3'd1, 3'd0, 3'd0, 3'd5};
        exp   = '{3'b101, 3'b111, 3'b101, 3'b100, 3'b000, 3'b000};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) start_write(leds[k], modes[k], 4'd15);
            else       cfgValid = 1'b0;
            n_checks++;
            if (cfgReady !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready k=%0d got %b expected 1", k, cfgReady);
            end
            step();
            n_checks++;
            if (ledOut !== exp[k] || cfgError !== 1'b0) begin
                n_fail++; $display("FAIL b2b k=%0d led=%b err=%b expected led=%b err=0", k, ledOut, cfgError, exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        do_reset();
        start_write(2'd1, 3'd2, 4'd15);
        step();
        cfgValid = 1'b0;
        while (t < 70) step();
        n_checks++;
        if (ledOut !== 3'b101) begin
            n_fail++; $display("FAIL mid_pre got %b expected 101", ledOut);
        end
        // Reset for one edge with a write pending; the write must be dropped.
        resetN = 1'b0;
        start_write(2'd0, 3'd0, 4'd0);
        #1;
        n_checks++;
        if (cfgReady !== 1'b0) begin
            n_fail++; $display("FAIL mid_ready got %b expected 0", cfgReady);
        end
        step();
        resetN   = 1'b1;
        cfgValid = 1'b0;
        t        = 0;
        n_checks++;
        if (ledOut !== RstPat) begin
            n_fail++; $display("FAIL mid_reset got %b expected %b", ledOut, RstPat);
        end
        repeat (60) begin
            step();
            n_checks++;
            if (ledOut !== RstPat) begin
                n_fail++; $display("FAIL mid_dropped t=%0d got %b expected %b", t, ledOut, RstPat);
            end
        end
        // Blink phase must line up with the restarted counters.
        start_write(2'd1, 3'd2, 4'd15);
        step();
        cfgValid = 1'b0;
        while (t < 130) begin
            step();
            exp = {1'b1, (((t - 1) / 50) % 2) == 0, 1'b1};
            n_checks++;
            if (ledOut !== exp) begin
                n_fail++; $display("FAIL mid_restart t=%0d got %b expected %b", t, ledOut, exp);
            end
        end
        // A write held through reset is accepted on the first released edge.
        resetN = 1'b0;
        start_write(2'd0, 3'd0, 4'd0);
        repeat (2) step();
        resetN = 1'b1;
        t      = 0;
        step();
        cfgValid = 1'b0;
        step();
        n_checks++;
        if (ledOut !== 3'b100) begin
            n_fail++; $display("FAIL first_write got %b expected 100", ledOut);
        end
    endtask

    initial begin
        resetN   = 1'b0;
        cfgValid = 1'b0;
        cfgLed   = 2'd0;
        cfgMode  = 3'd0;
        cfgLevel = 4'd0;
        attn     = 1'b0;
        test_reset();
        test_blink();
        test_pwm();
        test_heartbeat();
        test_error();
        test_attn();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oc_led_ctrl.md
OC_LED_CTRL -- requirements
Module: oc_led_ctrl

Interface
REQ-001 SHALL have parameter LedCount, default 3: number of LED outputs (1..32).
REQ-002 SHALL have parameter ClockHz, default 100_000_000: clock frequency.
REQ-003 SHALL have parameter TickHz, default 1000: timebase tick rate (1 ms).
REQ-004 SHALL have parameter PwmBits, default 8: brightness resolution.
REQ-005 SHALL have parameter BlinkHalfTicks, default 250: blink half-period in ticks.
REQ-006 SHALL have parameter ResetPattern [LedCount-1:0], default all ones: per-LED mode after reset (1=ON, 0=OFF).
REQ-007 SHALL have port clock, input, 1: sole clock; all logic on the rising edge.
REQ-008 SHALL have port resetN, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port cfgValid, input, 1: config write request.
REQ-010 SHALL have port cfgReady, output, 1: config write accepted when high with cfgValid.
REQ-011 SHALL have port cfgLed, input, $clog2(LedCount) (min 1): target LED index.
REQ-012 SHALL have port cfgMode, input, 3: mode code.
REQ-013 SHALL have port cfgLevel, input, PwmBits: PWM brightness.
REQ-014 SHALL have port cfgError, output, 1: one-cycle pulse on an accepted write with cfgLed >= LedCount.
REQ-015 SHALL have port attn, input, 1: attention override.
REQ-016 SHALL have port ledOut, output, LedCount: registered LED drives.

Function
REQ-017 Mode codes SHALL be 0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 HEARTBEAT; codes 5-7 SHALL behave as OFF but be stored as written.
REQ-018 Prescaler SHALL count 0..ClockHz/TickHz-1 and pulse tick for one cycle at terminal count.
REQ-019 Blink counter SHALL count ticks 0..BlinkHalfTicks-1 and toggle blinkPhase at wrap; blinkPhase resets to 1.
REQ-020 Heartbeat counter SHALL count ticks 0..999 and wrap; heartbeat is high for counts 0-99 and 200-299.
REQ-021 PWM counter SHALL be PwmBits wide, increment every clock, and wrap; a PWM LED is on when pwmCount < level (level 0 = never on; all-ones = 2^PwmBits-1 of 2^PwmBits cycles).
REQ-022 cfgReady SHALL be 1 whenever resetN is high; a write is accepted on any cycle where cfgValid and cfgReady are both high.
REQ-023 An accepted in-range write SHALL update mode[cfgLed] and level[cfgLed] at the next edge; ledOut SHALL reflect the new mode one cycle later, so latency is 2 cycles from the accept edge.
REQ-024 An out-of-range write SHALL change no state and SHALL assert cfgError in the following cycle.
REQ-025 ledOut[i] SHALL register attn OR modeFn(mode[i]); attn SHALL force all LEDs on with 1-cycle latency and remove the force with 1-cycle latency after it drops.
REQ-026 Counters SHALL free-run independently of config writes; a write SHALL NOT restart any counter.
REQ-027 Back-to-back writes SHALL be accepted every cycle; the last write to the same LED SHALL win.

Reset
REQ-028 While resetN is low at an edge: prescaler, blink, heartbeat and PWM counters SHALL be 0; blinkPhase 1; mode[i] ON or OFF per ResetPattern[i]; level all-ones; cfgError 0; cfgReady 0; ledOut = ResetPattern.
REQ-029 Reset asserted mid-write SHALL discard the write; the first write is accepted on the first cycle with resetN high.

Structure
REQ-030 The led_mode_e enum (3 bits) and mode constants SHALL live in oclib_pkg.
REQ-031 The prescaler SHALL be a sub-module oclib_tick_gen (params ClockHz, TickHz; ports clock, resetN, tick).

Verification (ClockHz=10000, TickHz=1000 => 10 cycles/tick, BlinkHalfTicks=5, PwmBits=4, LedCount=3)
REQ-032 Reset release with ResetPattern=3'b101, attn=0 -> ledOut=3'b101 in reset and held; cfgError stays 0.
REQ-033 Write LED1 BLINK -> ledOut[1]=1 for 50 cycles, then 0 for 50 cycles, repeating; LEDs 0 and 2 unchanged.
REQ-034 Write LED0 PWM level=4 -> ledOut[0] high 4 of every 16 cycles; level=0 -> always 0; level=15 -> 15 of 16.
REQ-035 Write LED2 HEARTBEAT -> high for cycles 0-999 and 2000-2999 of each 10000-cycle period, low otherwise.
REQ-036 cfgLed=3 write -> cfgError pulse 1 cycle, no ledOut change; attn=1 pulse of 3 cycles -> ledOut=3'b111 for exactly 3 cycles, delayed by 1.
REQ-037 resetN low for 1 cycle during blink with cfgValid high -> write dropped, counters restart, ledOut=ResetPattern.
